// File: rtl/matrix_entry_buffer_if.sv
// Bundle of the entry, display-read and streaming signals of matrix_entry_buffer.
// The buffer takes the slave modport; the driver of entries and the consumer
// of the stream sit on the master side.
interface matrix_entry_buffer_if #(
  parameter int DIM    = 8,
  parameter int DATA_W = 4
);
  localparam int IDX_W  = $clog2(DIM);
  localparam int FILL_W = $clog2(DIM*DIM+1);

  logic [IDX_W:0]    Size;
  logic              Wr;
  logic [IDX_W-1:0]  Wr_row;
  logic [IDX_W-1:0]  Wr_col;
  logic [DATA_W-1:0] Din;
  logic              Clr;
  logic              Start;
  logic [IDX_W-1:0]  Rd_row;
  logic [IDX_W-1:0]  Rd_col;
  logic [DATA_W-1:0] Rd_data;
  logic              Rd_valid;
  logic [FILL_W-1:0] Filled;
  logic              All_full;
  logic              Wr_err;
  logic              Busy;
  logic              Out_valid;
  logic              Out_ready;
  logic [DATA_W-1:0] Out_data;
  logic [IDX_W-1:0]  Out_row;
  logic [IDX_W-1:0]  Out_col;
  logic              Out_last;
  logic              Done;

  modport slave (
    input  Size, Wr, Wr_row, Wr_col, Din, Clr, Start, Rd_row, Rd_col, Out_ready,
    output Rd_data, Rd_valid, Filled, All_full, Wr_err, Busy,
           Out_valid, Out_data, Out_row, Out_col, Out_last, Done
  );

  modport master (
    output Size, Wr, Wr_row, Wr_col, Din, Clr, Start, Rd_row, Rd_col, Out_ready,
    input  Rd_data, Rd_valid, Filled, All_full, Wr_err, Busy,
           Out_valid, Out_data, Out_row, Out_col, Out_last, Done
  );
endinterface

// File: rtl/matrix_entry_buffer.sv
// Matrix entry buffer: stores up to DIM x DIM entries written from the switch
// entry logic, tracks which entries are filled, serves a combinational read
// port for the display and streams the active Size x Size block row-major to
// the determinant core over a valid/ready handshake.
module matrix_entry_buffer #(
  parameter int DIM    = 8,
  parameter int DATA_W = 4
) (
  input logic                  Clk,
  input logic                  Reset_n,
  matrix_entry_buffer_if.slave bus
);
  localparam int IDX_W  = $clog2(DIM);
  localparam int FILL_W = $clog2(DIM*DIM+1);

  localparam logic [IDX_W:0] DIM_N = (IDX_W+1)'(DIM);
  localparam logic [IDX_W:0] ONE_N = (IDX_W+1)'(1);

  localparam logic [0:0] ST_EDIT   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  logic [DATA_W-1:0] mem_q [DIM][DIM];
  logic              vld_q [DIM][DIM];

  logic [0:0]        state_q, state_d;
  logic [IDX_W:0]    n_q, n_d;
  logic [IDX_W-1:0]  row_q, row_d;
  logic [IDX_W-1:0]  col_q, col_d;
  logic              last_q, last_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [FILL_W-1:0] filled_q, filled_d;
  logic              wrErr_q, wrErr_d;

  logic [IDX_W:0]    nLive;
  logic              isEdit;
  logic              startAcc;
  logic              wrInRange;
  logic              wrAcc;
  logic              handshake;
  logic              allFull;
  logic [IDX_W:0]    colInc;
  logic              colWrap;
  logic [IDX_W-1:0]  nextRow;
  logic [IDX_W-1:0]  nextCol;
  logic              nextLast;

  // Clamp the live Size input into the legal range 1..DIM.
  always_comb begin
    nLive = bus.Size;
    if (bus.Size == '0) begin
      nLive = ONE_N;
    end else if (bus.Size > DIM_N) begin
      nLive = DIM_N;
    end
  end

  // Decide which request wins this cycle: Clr over Start over Wr.
  always_comb begin
    isEdit    = (state_q == ST_EDIT);
    startAcc  = !bus.Clr && bus.Start && isEdit;
    wrInRange = ({1'b0, bus.Wr_row} < nLive) && ({1'b0, bus.Wr_col} < nLive);
    wrAcc     = bus.Wr && !bus.Clr && !startAcc && isEdit && wrInRange;
    handshake = valid_q && bus.Out_ready;
  end

  // All_full looks only at the square selected by the live Size input.
  always_comb begin
    allFull = 1'b1;
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) begin
        if ((r < int'(nLive)) && (c < int'(nLive)) && !vld_q[r][c]) begin
          allFull = 1'b0;
        end
      end
    end
  end

  // Work out the coordinates of the beat that follows the current one.
  always_comb begin
    colInc   = {1'b0, col_q} + ONE_N;
    colWrap  = (colInc == n_q);
    nextCol  = colWrap ? '0 : colInc[IDX_W-1:0];
    nextRow  = colWrap ? row_q + 1'b1 : row_q;
    nextLast = ({1'b0, nextRow} == n_q - ONE_N) && ({1'b0, nextCol} == n_q - ONE_N);
  end

  // Entry storage; cleared by reset or Clr, otherwise written on an accepted Wr.
  always_ff @(posedge Clk) begin
    if (!Reset_n || bus.Clr) begin
      for (int r = 0; r < DIM; r++) begin
        for (int c = 0; c < DIM; c++) begin
          mem_q[r][c] <= '0;
          vld_q[r][c] <= 1'b0;
        end
      end
    end else if (wrAcc) begin
      mem_q[bus.Wr_row][bus.Wr_col] <= bus.Din;
      vld_q[bus.Wr_row][bus.Wr_col] <= 1'b1;
    end
  end

  // Fill count and the rejected-write pulse.
  always_comb begin
    filled_d = filled_q;
    wrErr_d  = bus.Wr && !wrAcc;
    if (bus.Clr) begin
      filled_d = '0;
    end else if (wrAcc && !vld_q[bus.Wr_row][bus.Wr_col]) begin
      filled_d = filled_q + FILL_W'(1);
    end
  end

  // Stream sequencing: start, advance on handshake, finish or abort.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    row_d   = row_q;
    col_d   = col_q;
    last_d  = last_q;
    valid_d = valid_q;
    data_d  = data_q;
    done_d  = 1'b0;
    if (bus.Clr) begin
      state_d = ST_EDIT;
      valid_d = 1'b0;
      last_d  = 1'b0;
    end else if (startAcc) begin
      state_d = ST_STREAM;
      n_d     = nLive;
      row_d   = '0;
      col_d   = '0;
      last_d  = (nLive == ONE_N);
      valid_d = 1'b1;
      data_d  = mem_q[0][0];
    end else if (handshake) begin
      if (last_q) begin
        state_d = ST_EDIT;
        valid_d = 1'b0;
        last_d  = 1'b0;
        done_d  = 1'b1;
      end else begin
        row_d  = nextRow;
        col_d  = nextCol;
        last_d = nextLast;
        data_d = mem_q[nextRow][nextCol];
      end
    end
  end

  // Control and stream registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q  <= ST_EDIT;
      n_q      <= ONE_N;
      row_q    <= '0;
      col_q    <= '0;
      last_q   <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      data_q   <= '0;
      filled_q <= '0;
      wrErr_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      row_q    <= row_d;
      col_q    <= col_d;
      last_q   <= last_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      data_q   <= data_d;
      filled_q <= filled_d;
      wrErr_q  <= wrErr_d;
    end
  end

  assign bus.Rd_data   = mem_q[bus.Rd_row][bus.Rd_col];
  assign bus.Rd_valid  = vld_q[bus.Rd_row][bus.Rd_col];
  assign bus.Filled    = filled_q;
  assign bus.All_full  = allFull;
  assign bus.Wr_err    = wrErr_q;
  assign bus.Busy      = (state_q == ST_STREAM);
  assign bus.Out_valid = valid_q;
  assign bus.Out_data  = data_q;
  assign bus.Out_row   = row_q;
  assign bus.Out_col   = col_q;
  assign bus.Out_last  = last_q;
  assign bus.Done      = done_q;
endmodule

// File: tb/tb_matrix_entry_buffer.sv
// Testbench for matrix_entry_buffer: directed entry/stream scenarios plus
// randomized writes and streams checked against an array-based reference.
module tb_matrix_entry_buffer;
  localparam int DIM    = 8;
  localparam int DATA_W = 4;
  localparam int IDX_W  = $clog2(DIM);

  logic clk = 1'b0;
  logic rstN;

  always #5 clk = ~clk;

  matrix_entry_buffer_if #(.DIM(DIM), .DATA_W(DATA_W)) bus ();

  matrix_entry_buffer #(.DIM(DIM), .DATA_W(DATA_W)) dut (
    .Clk     (clk),
    .Reset_n (rstN),
    .bus     (bus)
  );

  int refMem [DIM][DIM];
  bit refVld [DIM][DIM];
  int errors = 0;
  int checks = 0;

  // Compare one observed value against the expected one.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int appliedN(input int s);
    if (s < 1) return 1;
    if (s > DIM) return DIM;
    return s;
  endfunction

  function automatic int refFilled();
    int cnt = 0;
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++)
        if (refVld[r][c]) cnt++;
    return cnt;
  endfunction

  function automatic int refAllFull(input int s);
    int n = appliedN(s);
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++)
        if (!refVld[r][c]) return 0;
    return 1;
  endfunction

  function automatic void refClear();
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        refMem[r][c] = 0;
        refVld[r][c] = 1'b0;
      end
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic readCheck(input int r, input int c);
    bus.Rd_row = IDX_W'(r);
    bus.Rd_col = IDX_W'(c);
    #1;
    checkOutput($sformatf("rd_data(%0d,%0d)", r, c), int'(bus.Rd_data), refMem[r][c]);
    checkOutput($sformatf("rd_valid(%0d,%0d)", r, c), int'(bus.Rd_valid), int'(refVld[r][c]));
  endtask

  // One write in EDIT at the current Size, then check the status outputs.
  task automatic applyStimulus(input int r, input int c, input int d);
    int n;
    int expErr;
    n = appliedN(int'(bus.Size));
    bus.Wr     = 1'b1;
    bus.Wr_row = IDX_W'(r);
    bus.Wr_col = IDX_W'(c);
    bus.Din    = DATA_W'(d);
    tick();
    bus.Wr = 1'b0;
    if (r < n && c < n) begin
      refMem[r][c] = d;
      refVld[r][c] = 1'b1;
      expErr = 0;
    end else begin
      expErr = 1;
    end
    #1;
    checkOutput("wr_err", int'(bus.Wr_err), expErr);
    checkOutput("filled", int'(bus.Filled), refFilled());
    checkOutput("all_full", int'(bus.All_full), refAllFull(int'(bus.Size)));
  endtask

  // Start a stream of size s; mode 0 ready always, 1 pattern 1,0,0, 2 random.
  task automatic runStream(input int s, input int mode, input int abortAfter, input bit withWr);
    int n, hs, budget, rdy, wr;
    int qr[$], qc[$], qd[$];
    bus.Size = (IDX_W+1)'(s);
    n = appliedN(s);
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) begin
        qr.push_back(r);
        qc.push_back(c);
        qd.push_back(refMem[r][c]);
      end
    bus.Start  = 1'b1;
    bus.Wr     = withWr;
    bus.Wr_row = '0;
    bus.Wr_col = '0;
    bus.Din    = 4'hF;
    tick();
    bus.Start = 1'b0;
    bus.Wr    = 1'b0;
    checkOutput("start_wr_err", int'(bus.Wr_err), int'(withWr));
    hs = 0;
    budget = 0;
    while (qr.size() > 0) begin
      if (budget > 4*DIM*DIM + 20) begin
        checkOutput("stream_timeout", budget, 4*DIM*DIM + 20);
        break;
      end
      checkOutput("out_valid", int'(bus.Out_valid), 1);
      checkOutput("busy", int'(bus.Busy), 1);
      checkOutput("out_data", int'(bus.Out_data), qd[0]);
      checkOutput("out_row", int'(bus.Out_row), qr[0]);
      checkOutput("out_col", int'(bus.Out_col), qc[0]);
      checkOutput("out_last", int'(bus.Out_last), int'(qr.size() == 1));
      checkOutput("done_early", int'(bus.Done), 0);
      if (abortAfter >= 0 && hs == abortAfter) begin
        bus.Clr = 1'b1;
        tick();
        bus.Clr = 1'b0;
        refClear();
        checkOutput("abort_valid", int'(bus.Out_valid), 0);
        checkOutput("abort_busy", int'(bus.Busy), 0);
        checkOutput("abort_filled", int'(bus.Filled), 0);
        checkOutput("abort_done", int'(bus.Done), 0);
        tick();
        checkOutput("abort_done2", int'(bus.Done), 0);
        return;
      end
      if (mode == 0) rdy = 1;
      else if (mode == 1) rdy = int'((budget % 3) == 0);
      else rdy = int'($urandom_range(0, 1));
      wr = int'($urandom_range(0, 3) == 0);
      bus.Wr        = wr[0];
      bus.Wr_row    = IDX_W'($urandom_range(0, n - 1));
      bus.Wr_col    = IDX_W'($urandom_range(0, n - 1));
      bus.Din       = DATA_W'($urandom);
      bus.Out_ready = rdy[0];
      budget++;
      tick();
      bus.Out_ready = 1'b0;
      bus.Wr        = 1'b0;
      checkOutput("stream_wr_err", int'(bus.Wr_err), wr);
      if (rdy != 0) begin
        void'(qr.pop_front());
        void'(qc.pop_front());
        void'(qd.pop_front());
        hs++;
      end
    end
    checkOutput("done", int'(bus.Done), 1);
    checkOutput("end_valid", int'(bus.Out_valid), 0);
    checkOutput("end_busy", int'(bus.Busy), 0);
    checkOutput("handshakes", hs, n * n);
    tick();
    checkOutput("done_pulse", int'(bus.Done), 0);
  endtask

  initial begin
    rstN          = 1'b0;
    bus.Size      = 4'd3;
    bus.Wr        = 1'b0;
    bus.Wr_row    = '0;
    bus.Wr_col    = '0;
    bus.Din       = '0;
    bus.Clr       = 1'b0;
    bus.Start     = 1'b0;
    bus.Rd_row    = '0;
    bus.Rd_col    = '0;
    bus.Out_ready = 1'b0;
    refClear();
    tick();
    tick();
    rstN = 1'b1;
    #1;
    checkOutput("rst_filled", int'(bus.Filled), 0);
    checkOutput("rst_busy", int'(bus.Busy), 0);
    checkOutput("rst_valid", int'(bus.Out_valid), 0);
    checkOutput("rst_last", int'(bus.Out_last), 0);
    checkOutput("rst_done", int'(bus.Done), 0);
    checkOutput("rst_wr_err", int'(bus.Wr_err), 0);
    checkOutput("rst_data", int'(bus.Out_data), 0);
    readCheck(0, 0);

    // Fill a 3x3 diagonal, then the rest.
    applyStimulus(0, 0, 1);
    applyStimulus(1, 1, 2);
    applyStimulus(2, 2, 3);
    readCheck(1, 1);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        if (r != c) applyStimulus(r, c, r * 3 + c);
    checkOutput("full_3x3", int'(bus.All_full), 1);

    // Out-of-range write and overwrite.
    applyStimulus(3, 0, 5);
    readCheck(3, 0);
    applyStimulus(0, 0, 7);
    readCheck(0, 0);
    tick();
    checkOutput("wr_err_clear", int'(bus.Wr_err), 0);

    // Size-2 streams with steady and toggling ready.
    bus.Size = 4'd2;
    applyStimulus(0, 0, 1);
    applyStimulus(0, 1, 2);
    applyStimulus(1, 0, 3);
    applyStimulus(1, 1, 4);
    runStream(2, 0, -1, 1'b0);
    runStream(2, 1, -1, 1'b0);

    // Abort a size-3 stream after two handshakes, then restart on zeros.
    runStream(3, 0, 2, 1'b0);
    runStream(3, 0, -1, 1'b0);

    // Size 0 gives one beat; Wr with Start is rejected.
    runStream(0, 0, -1, 1'b1);

    // Randomized writes at random sizes with occasional clears.
    for (int i = 0; i < 120; i++) begin
      bus.Size = (IDX_W+1)'($urandom_range(0, 15));
      if ($urandom_range(0, 29) == 0) begin
        bus.Clr = 1'b1;
        tick();
        bus.Clr = 1'b0;
        refClear();
        #1;
        checkOutput("clr_filled", int'(bus.Filled), 0);
      end else begin
        applyStimulus(int'($urandom_range(0, DIM - 1)), int'($urandom_range(0, DIM - 1)),
                      int'($urandom_range(0, 15)));
      end
      readCheck(int'($urandom_range(0, DIM - 1)), int'($urandom_range(0, DIM - 1)));
    end

    // Oversized request covers the full 8x8, then a few random streams.
    runStream(9, 2, -1, 1'b0);
    for (int i = 0; i < 3; i++) runStream(int'($urandom_range(0, 15)), 2, -1, 1'b0);

    // Reset in the middle of a stream.
    bus.Size  = 4'd4;
    bus.Start = 1'b1;
    tick();
    bus.Start     = 1'b0;
    bus.Out_ready = 1'b1;
    tick();
    tick();
    bus.Out_ready = 1'b0;
    rstN = 1'b0;
    tick();
    rstN = 1'b1;
    refClear();
    #1;
    checkOutput("mid_rst_busy", int'(bus.Busy), 0);
    checkOutput("mid_rst_valid", int'(bus.Out_valid), 0);
    checkOutput("mid_rst_filled", int'(bus.Filled), 0);
    checkOutput("mid_rst_row", int'(bus.Out_row), 0);
    checkOutput("mid_rst_col", int'(bus.Out_col), 0);
    tick();
    checkOutput("mid_rst_done", int'(bus.Done), 0);
    readCheck(0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
